// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the RV32I fetch stage
package fetch_unit_pkg;

  typedef logic [6:0] opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - PC/OldPC registers with increment, redirect and alignment check
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] old_pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic            aligned;

  assign aligned      = (target_i[1:0] == 2'b00);
  assign misaligned_o = redirect_en_i & ~aligned;

  // Advance and redirect are mutually exclusive: advance only happens in REQ/WAIT.
  always_comb begin
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    if (advance_i) begin
      old_pc_d = pc_q;
      pc_d     = pc_q + XLEN'(4);
    end else if (redirect_en_i && aligned) begin
      pc_d = target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
    end else begin
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign old_pc_o = old_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, instruction register and imem request FSM
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0],
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ir_write,
  input  logic            pc_update,
  input  logic            branch,
  input  logic            zero_flag,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output opcode_t         opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            fetch_busy,
  output logic            fetch_done,
  output logic            misaligned_fault,
  output logic            timeout_fault
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  fetch_state_t state_q, state_d;
  logic         ir_write_q;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  instr_q, instr_d;
  logic         fetch_done_q, fetch_done_d;
  logic         mis_q, mis_d;
  logic         to_q, to_d;

  logic start;
  logic redirect_req;
  logic redirect_en;
  logic accept;
  logic misaligned;

  assign start        = ir_write & ~ir_write_q;
  assign redirect_req = pc_update | (branch & zero_flag);
  assign redirect_en  = (state_q == ST_IDLE) & redirect_req;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .redirect_en_i (redirect_en),
    .target_i      (pc_target),
    .advance_i     (accept),
    .pc_o          (pc),
    .old_pc_o      (old_pc),
    .misaligned_o  (misaligned)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    instr_d      = instr_q;
    mis_d        = mis_q;
    to_d         = to_q;
    accept       = 1'b0;
    imem_req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A misaligned redirect wins over a simultaneous fetch start.
        if (misaligned) begin
          mis_d   = 1'b1;
          state_d = ST_FAULT;
        end else if (start) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        imem_req = 1'b1;
        cnt_d    = 8'd0;
        if (imem_rvalid) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            to_d    = 1'b1;
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) instr_d = imem_rdata;
    fetch_done_d = accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ir_write_q   <= 1'b0;
      cnt_q        <= 8'd0;
      instr_q      <= NOP_INSTR;
      fetch_done_q <= 1'b0;
      mis_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_write_q   <= ir_write;
      cnt_q        <= cnt_d;
      instr_q      <= instr_d;
      fetch_done_q <= fetch_done_d;
      mis_q        <= mis_d;
      to_q         <= to_d;
    end
  end

  assign imem_addr        = pc;
  assign instr            = instr_q;
  assign opcode           = instr_q[6:0];
  assign fetch_busy       = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign fetch_done       = fetch_done_q;
  assign misaligned_fault = mis_q;
  assign timeout_fault    = to_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_write, pc_update, branch, zero_flag;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  opcode_t     opcode;
  logic [31:0] pc, old_pc;
  logic        fetch_busy, fetch_done, misaligned_fault, timeout_fault;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .ir_write         (ir_write),
    .pc_update        (pc_update),
    .branch           (branch),
    .zero_flag        (zero_flag),
    .pc_target        (pc_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr            (instr),
    .opcode           (opcode),
    .pc               (pc),
    .old_pc           (old_pc),
    .fetch_busy       (fetch_busy),
    .fetch_done       (fetch_done),
    .misaligned_fault (misaligned_fault),
    .timeout_fault    (timeout_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ir_write = 1'b0; pc_update = 1'b0; branch = 1'b0; zero_flag = 1'b0;
    pc_target = '0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_done", {31'd0, fetch_done}, 32'd0);
    check("rst_faults", {30'd0, misaligned_fault, timeout_fault}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);

    // basic fetch with one wait cycle
    ir_write = 1'b1;
    tick();
    check("f1_req", {31'd0, imem_req}, 32'd1);
    check("f1_addr", imem_addr, 32'h0);
    check("f1_busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    check("f1_req_gone", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_0093;
    tick();
    imem_rvalid = 1'b0;
    check("f1_instr", instr, 32'h0020_0093);
    check("f1_opcode", {25'd0, opcode}, 32'h13);
    check("f1_pc", pc, 32'h4);
    check("f1_old_pc", old_pc, 32'h0);
    check("f1_done", {31'd0, fetch_done}, 32'd1);
    tick();
    check("f1_done_pulse", {31'd0, fetch_done}, 32'd0);

    // ir_write held high: exactly one request
    ir_write = 1'b0;
    tick();
    ir_write = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req) begin
        n++;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
      end else begin
        imem_rvalid = 1'b0;
      end
    end
    imem_rvalid = 1'b0; ir_write = 1'b0;
    tick();
    check("held_req_count", n, 32'd1);
    check("held_pc", pc, 32'h8);
    check("held_old_pc", old_pc, 32'h4);

    // conditional branch taken / not taken
    branch = 1'b1; zero_flag = 1'b1; pc_target = 32'h40;
    tick();
    check("br_taken", pc, 32'h40);
    zero_flag = 1'b0; pc_target = 32'h200;
    tick();
    branch = 1'b0;
    check("br_not_taken", pc, 32'h40);

    // start and redirect in the same cycle
    ir_write = 1'b1; pc_update = 1'b1; pc_target = 32'h80;
    tick();
    pc_update = 1'b0;
    check("sr_pc", pc, 32'h80);
    check("sr_req", {31'd0, imem_req}, 32'd1);
    check("sr_addr", imem_addr, 32'h80);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_rvalid = 1'b0; ir_write = 1'b0;
    check("sr_pc_next", pc, 32'h84);
    check("sr_old_pc", old_pc, 32'h80);
    check("sr_instr", instr, 32'h0000_0033);
    tick();

    // PC wrap
    pc_update = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    pc_update = 1'b0; ir_write = 1'b1;
    tick();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
    tick();
    imem_rvalid = 1'b0; ir_write = 1'b0;
    check("wrap_pc", pc, 32'h0);
    check("wrap_old_pc", old_pc, 32'hFFFF_FFFC);
    check("wrap_opcode", {25'd0, opcode}, 32'h73);
    tick();

    // misaligned redirect locks into FAULT
    pc_update = 1'b1; pc_target = 32'h102;
    tick();
    pc_update = 1'b0;
    check("mis_fault", {31'd0, misaligned_fault}, 32'd1);
    check("mis_pc", pc, 32'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      ir_write = i[0];
      tick();
      if (imem_req) n++;
    end
    ir_write = 1'b0;
    check("mis_no_req", n, 32'd0);
    check("mis_sticky", {31'd0, misaligned_fault}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mis_reset_clear", {31'd0, misaligned_fault}, 32'd0);

    // timeout after 255 WAIT cycles
    pc_update = 1'b1; pc_target = 32'h40;
    tick();
    pc_update = 1'b0; ir_write = 1'b1;
    tick();
    check("to_req", {31'd0, imem_req}, 32'd1);
    n = 0;
    while (!timeout_fault && n < 400) begin
      tick();
      n++;
    end
    ir_write = 1'b0;
    check("to_cycles", n, 32'd256);
    check("to_fault", {31'd0, timeout_fault}, 32'd1);
    check("to_busy", {31'd0, fetch_busy}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("to_reset_clear", {31'd0, timeout_fault}, 32'd0);
    check("to_reset_pc", pc, 32'h0);

    // reset during WAIT, late rvalid ignored
    tick();
    ir_write = 1'b1;
    tick();
    tick();
    check("rw_busy", {31'd0, fetch_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; ir_write = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    tick();
    check("rw_instr", instr, 32'h0000_0013);
    check("rw_done", {31'd0, fetch_done}, 32'd0);
    check("rw_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
